// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: DEPTH slices with valid, flush, stall and a saturating stall counter.
// Optional per-slice forwarding taps are enabled with the PIPE_STAGE_REG_FWD_EN macro.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 2,
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  input  logic [CTRL_W-1:0]       ctrl_i,
  input  logic [LANES*DATA_W-1:0] data_i,
  input  logic [RD_W-1:0]         rd_i,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic                    clr_cnt_i,
  output logic                    valid_o,
  output logic [CTRL_W-1:0]       ctrl_o,
  output logic [LANES*DATA_W-1:0] data_o,
  output logic [RD_W-1:0]         rd_o,
  output logic [CNT_W-1:0]        stall_cnt_o
`ifdef PIPE_STAGE_REG_FWD_EN
  ,
  output logic [DEPTH-1:0]        fwd_valid_o,
  output logic [DEPTH-1:0]        fwd_we_o,
  output logic [DEPTH*RD_W-1:0]   fwd_rd_o
`endif
);

  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $fatal(1, "pipe_stage_reg: DEPTH must be in 1..4");
    end
  endgenerate

  logic                    r_valid [DEPTH];
  logic [CTRL_W-1:0]       r_ctrl  [DEPTH];
  logic [LANES*DATA_W-1:0] r_data  [DEPTH];
  logic [RD_W-1:0]         r_rd    [DEPTH];
  logic [CNT_W-1:0]        r_cnt;

  logic                    w_src_valid [DEPTH];
  logic [CTRL_W-1:0]       w_src_ctrl  [DEPTH];
  logic [LANES*DATA_W-1:0] w_src_data  [DEPTH];
  logic [RD_W-1:0]         w_src_rd    [DEPTH];

  // Slice 0 is fed by the inputs, every later slice by its predecessor.
  always_comb begin
    w_src_valid[0] = valid_i;
    w_src_ctrl[0]  = ctrl_i;
    w_src_data[0]  = data_i;
    w_src_rd[0]    = rd_i;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      w_src_valid[k] = r_valid[k-1];
      w_src_ctrl[k]  = r_ctrl[k-1];
      w_src_data[k]  = r_data[k-1];
      w_src_rd[k]    = r_rd[k-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_valid[k] <= 1'b0;
        r_ctrl[k]  <= '0;
        r_data[k]  <= '0;
        r_rd[k]    <= '0;
      end
    end else if (flush_i) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_valid[k] <= 1'b0;
        r_ctrl[k]  <= '0;
      end
    end else if (!stall_i) begin
      // Bubbles keep their stale data/rd to avoid toggling the wide datapath.
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_valid[k] <= w_src_valid[k];
        if (w_src_valid[k]) begin
          r_ctrl[k] <= w_src_ctrl[k];
          r_data[k] <= w_src_data[k];
          r_rd[k]   <= w_src_rd[k];
        end else begin
          r_ctrl[k] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (clr_cnt_i) begin
      r_cnt <= '0;
    end else if (stall_i && !flush_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign valid_o     = r_valid[DEPTH-1];
  assign ctrl_o      = r_ctrl[DEPTH-1] & {CTRL_W{r_valid[DEPTH-1]}};
  assign data_o      = r_data[DEPTH-1];
  assign rd_o        = r_rd[DEPTH-1];
  assign stall_cnt_o = r_cnt;

`ifdef PIPE_STAGE_REG_FWD_EN
  always_comb begin
    fwd_valid_o = '0;
    fwd_we_o    = '0;
    fwd_rd_o    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fwd_valid_o[k]            = r_valid[k];
      fwd_we_o[k]               = r_valid[k] & r_ctrl[k][0];
      fwd_rd_o[k*RD_W +: RD_W]  = r_rd[k];
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (DEPTH=2, CNT_W=4): vector table plus hand-written corner sequences.
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 2;
  localparam int unsigned CTRL_W = 2;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DW     = LANES*DATA_W;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              valid_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic [DW-1:0]     data_i;
  logic [RD_W-1:0]   rd_i;
  logic              stall_i;
  logic              flush_i;
  logic              clr_cnt_i;
  logic              valid_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DW-1:0]     data_o;
  logic [RD_W-1:0]   rd_o;
  logic [CNT_W-1:0]  stall_cnt_o;
`ifdef PIPE_STAGE_REG_FWD_EN
  logic [DEPTH-1:0]      fwd_valid_o;
  logic [DEPTH-1:0]      fwd_we_o;
  logic [DEPTH*RD_W-1:0] fwd_rd_o;
`endif

  pipe_stage_reg #(
    .DATA_W(DATA_W), .LANES(LANES), .CTRL_W(CTRL_W),
    .RD_W(RD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) u_dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ctrl_i(ctrl_i),
    .data_i(data_i), .rd_i(rd_i), .stall_i(stall_i), .flush_i(flush_i),
    .clr_cnt_i(clr_cnt_i), .valid_o(valid_o), .ctrl_o(ctrl_o),
    .data_o(data_o), .rd_o(rd_o), .stall_cnt_o(stall_cnt_o)
`ifdef PIPE_STAGE_REG_FWD_EN
    , .fwd_valid_o(fwd_valid_o), .fwd_we_o(fwd_we_o), .fwd_rd_o(fwd_rd_o)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [DW-1:0]     data;
    logic [RD_W-1:0]   rd;
    logic              stall;
    logic              flush;
    logic              clr;
    logic              e_valid;
    logic [CTRL_W-1:0] e_ctrl;
    logic [DW-1:0]     e_data;
    logic [RD_W-1:0]   e_rd;
    logic [CNT_W-1:0]  e_cnt;
  } vec_t;

  localparam logic [DW-1:0] D_D = {32'hDEAD_BEEF, 32'h0000_1234};
  localparam logic [DW-1:0] D_A = {32'h1111_1111, 32'h2222_2222};
  localparam logic [DW-1:0] D_B = {32'h3333_3333, 32'h4444_4444};
  localparam logic [DW-1:0] D_C = {32'h5555_5555, 32'h6666_6666};
  localparam logic [DW-1:0] D_E = {32'hEEEE_EEEE, 32'hEEEE_EEEE};
  localparam logic [DW-1:0] D_F = {32'hF0F0_F0F0, 32'h0F0F_0F0F};

  vec_t tbl [12];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [CTRL_W-1:0] c,
                         input logic [DW-1:0] d, input logic [RD_W-1:0] r, input logic [CNT_W-1:0] n);
    chk({tag, " valid_o"}, DW'(valid_o), DW'(v));
    chk({tag, " ctrl_o"}, DW'(ctrl_o), DW'(c));
    chk({tag, " data_o"}, data_o, d);
    chk({tag, " rd_o"}, DW'(rd_o), DW'(r));
    chk({tag, " stall_cnt_o"}, DW'(stall_cnt_o), DW'(n));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DW-1:0] d,
                       input logic [RD_W-1:0] r, input logic s, input logic f, input logic cl);
    valid_i = v; ctrl_i = c; data_i = d; rd_i = r;
    stall_i = s; flush_i = f; clr_cnt_i = cl;
  endtask

  initial begin
    // valid ctrl data rd stall flush clr | exp valid ctrl data rd cnt
    tbl[0]  = '{1'b1, 2'b11, D_A, 5'd1,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, D_D, 5'd7, 4'd0};
    tbl[1]  = '{1'b1, 2'b10, D_B, 5'd2,  1'b0, 1'b0, 1'b0, 1'b1, 2'b11, D_A, 5'd1, 4'd0};
    tbl[2]  = '{1'b0, 2'b11, D_E, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, D_B, 5'd2, 4'd0};
    tbl[3]  = '{1'b1, 2'b01, D_C, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, D_B, 5'd2, 4'd0};
    tbl[4]  = '{1'b1, 2'b11, D_F, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, D_B, 5'd2, 4'd1};
    tbl[5]  = '{1'b0, 2'b00, D_E, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 2'b01, D_C, 5'd3, 4'd1};
    tbl[6]  = '{1'b1, 2'b11, D_A, 5'd1,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, D_C, 5'd3, 4'd1};
    tbl[7]  = '{1'b1, 2'b10, D_B, 5'd2,  1'b0, 1'b0, 1'b1, 1'b1, 2'b11, D_A, 5'd1, 4'd0};
    tbl[8]  = '{1'b1, 2'b01, D_C, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, D_A, 5'd1, 4'd0};
    tbl[9]  = '{1'b0, 2'b11, D_E, 5'd30, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, D_A, 5'd1, 4'd0};
    tbl[10] = '{1'b0, 2'b00, D_E, 5'd30, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, D_A, 5'd1, 4'd1};
    tbl[11] = '{1'b0, 2'b00, D_E, 5'd30, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, D_A, 5'd1, 4'd0};

    rst_i = 1'b0;
    drive(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, 1'b0);
    #12;
    chk_out("reset_low", 1'b0, 2'b00, '0, 5'd0, 4'd0);
    rst_i = 1'b1;
    step();
    chk_out("reset_release", 1'b0, 2'b00, '0, 5'd0, 4'd0);

    // Two-edge latency, then a bubble follows with data/rd held.
    drive(1'b1, 2'b01, D_D, 5'd7, 1'b0, 1'b0, 1'b0);
    step();
    chk("lat edge1 valid_o", DW'(valid_o), DW'(1'b0));
    drive(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("lat edge2", 1'b1, 2'b01, D_D, 5'd7, 4'd0);
    step();
    chk_out("lat edge3", 1'b0, 2'b00, D_D, 5'd7, 4'd0);

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].valid, tbl[i].ctrl, tbl[i].data, tbl[i].rd,
            tbl[i].stall, tbl[i].flush, tbl[i].clr);
      step();
      chk_out($sformatf("row%0d", i), tbl[i].e_valid, tbl[i].e_ctrl,
              tbl[i].e_data, tbl[i].e_rd, tbl[i].e_cnt);
    end

    // Stall hold: both slices carry rd=3, then a stalled rd=9 must not be captured.
    drive(1'b1, 2'b01, D_C, 5'd3, 1'b0, 1'b0, 1'b1);
    step();
    step();
    chk_out("hold pre", 1'b1, 2'b01, D_C, 5'd3, 4'd0);
    drive(1'b1, 2'b11, D_F, 5'd9, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk_out($sformatf("hold stall%0d", i), 1'b1, 2'b01, D_C, 5'd3, CNT_W'(i));
    end
    stall_i = 1'b0;
    step();
    chk("hold rel1 rd_o", DW'(rd_o), DW'(5'd3));
    step();
    chk_out("hold rel2", 1'b1, 2'b11, D_F, 5'd9, 4'd3);

    // Saturation from 3: reaches 15 after 12 stalled edges and stays there.
    stall_i = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 12 || i == 20)
        chk($sformatf("sat after %0d", i), DW'(stall_cnt_o), DW'(4'd15));
    end
    clr_cnt_i = 1'b1;
    step();
    chk("clr wins", DW'(stall_cnt_o), DW'(4'd0));
    clr_cnt_i = 1'b0;
    step();
    chk("clr then inc", DW'(stall_cnt_o), DW'(4'd1));

    // Asynchronous reset between edges with the pipe full.
    drive(1'b1, 2'b11, D_A, 5'd1, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk_out("async pre", 1'b1, 2'b11, D_A, 5'd1, 4'd1);
    #2;
    rst_i = 1'b0;
    #1;
    chk_out("async mid", 1'b0, 2'b00, '0, 5'd0, 4'd0);
    step();
    chk_out("async held", 1'b0, 2'b00, '0, 5'd0, 4'd0);
    rst_i = 1'b1;
    drive(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("async release", 1'b0, 2'b00, '0, 5'd0, 4'd0);

`ifdef PIPE_STAGE_REG_FWD_EN
    drive(1'b1, 2'b01, D_A, 5'd6, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 2'b00, D_E, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 2'b01, D_B, 5'd4, 1'b0, 1'b0, 1'b0);
    step();
    chk("fwd_rd_o", DW'(fwd_rd_o), DW'({5'd6, 5'd4}));
    chk("fwd_valid_o", DW'(fwd_valid_o), DW'(2'b01));
    chk("fwd_we_o", DW'(fwd_we_o), DW'(2'b01));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register that generalises the fixed MEM/WB latch. It carries a configurable control vector, data lanes and a destination register address through DEPTH register slices. It adds a valid bit per slice, flush (bubble injection), stall hold and a saturating stall-cycle counter. It sits between any two CPU pipeline stages, for example EX/MEM or MEM/WB, with the hazard unit driving stall_i and flush_i.

Parameters:
DATA_W, 32, width of one data lane
LANES, 2, number of data lanes (e.g. ReadData + ALU result)
CTRL_W, 2, control-vector width; bit 0 is the register-write enable
RD_W, 5, destination register address width
DEPTH, 1, number of register slices (1..4)
CNT_W, 16, stall counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
valid_i  in  1  upstream slot holds a real instruction
ctrl_i  in  CTRL_W  control vector
data_i  in  LANES*DATA_W  packed data lanes, lane 0 in LSBs
rd_i  in  RD_W  destination register address
stall_i  in  1  hold all slices
flush_i  in  1  kill all slices
clr_cnt_i  in  1  synchronous clear of the stall counter
valid_o  in/out: out  1  last-slice valid
ctrl_o  out  CTRL_W  last-slice control; forced 0 when valid_o=0
data_o  out  LANES*DATA_W  last-slice data
rd_o  out  RD_W  last-slice destination address
stall_cnt_o  out  CNT_W  stall cycles counted since reset or clear

Behaviour:
- Reset (rst_i=0, asynchronous): every slice has valid=0, ctrl=0, data=0 and rd=0; stall_cnt_o=0. All outputs read 0 while reset is low and on the first edge after release.
- Slice k (k=0..DEPTH-1): slice 0 loads from the inputs, slice k loads from slice k-1. Outputs are driven by slice DEPTH-1.
- Latency: DEPTH cycles from input to output when no stall occurs.
- Priority per rising edge: flush_i, then stall_i, then normal advance.
- flush_i=1: all slices get valid=0 and ctrl=0. data and rd are held. flush_i overrides stall_i in the same cycle.
- stall_i=1, flush_i=0: every slice holds all of its fields unchanged. Inputs are ignored and are not captured later.
- Normal advance: each slice takes valid from its source.
  - Source valid=1: ctrl, data and rd are copied.
  - Source valid=0: ctrl is set to 0; data and rd are held, which avoids needless toggling.
- ctrl_o is the registered ctrl ANDed with valid_o. A killed slot can therefore never assert register write.
- Stall counter:
  - Increments by 1 on each edge where stall_i=1 and flush_i=0.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - clr_cnt_i=1 sets it to 0 on that edge; the clear wins over a simultaneous increment.
- Reset asserted mid-operation: all state clears immediately, with no dependence on the clock. In-flight instructions are lost and valid_o drops at once.
- DEPTH outside 1..4 is a fatal error at elaboration.

Optional Feature:
Macro: PIPE_STAGE_REG_FWD_EN
- Defined: adds outputs fwd_valid_o [DEPTH], fwd_we_o [DEPTH] (ctrl bit 0 AND valid, per slice) and fwd_rd_o [DEPTH*RD_W], with slice 0 in the LSBs. These expose every slice for hazard and forwarding comparison.
  - A slice with valid=0 reports we=0 regardless of its held rd.
  - The taps are combinational from slice registers only, with no path from the inputs.
- Undefined: these ports do not exist and the slice logic is unchanged.

Test Plan:
- Reset/latency, DEPTH=2: release rst_i; drive valid_i=1, ctrl_i=2'b01, data_i={32'hDEAD_BEEF,32'h0000_1234}, rd_i=5'd7 for one cycle, then valid_i=0. The data appears at the outputs exactly 2 edges later with valid_o=1, ctrl_o=01, rd_o=7. On the next edge valid_o=0 and ctrl_o=0, while data_o and rd_o keep their values.
- Stall hold: DEPTH=1, outputs hold rd_o=3. Assert stall_i for 3 cycles while rd_i=9 and valid_i=1. Outputs stay rd_o=3 and stall_cnt_o goes 0,1,2,3. After release, rd_o=9 on the next edge.
- Flush vs stall: assert stall_i=1 and flush_i=1 together with valid_o=1 and ctrl_o=11. After the edge, valid_o=0, ctrl_o=00, rd_o and data_o are unchanged, and stall_cnt_o does not increment.
- Counter saturation/clear: CNT_W=4; hold stall_i for 20 cycles, so stall_cnt_o=15. Pulse clr_cnt_i with stall_i=1 still high; stall_cnt_o=0 after that edge and 1 after the following edge.
- Async reset mid-flight: DEPTH=3 with all slices valid; pull rst_i low between clock edges. valid_o, ctrl_o, data_o, rd_o and stall_cnt_o go to 0 before the next edge.
- FWD taps (PIPE_STAGE_REG_FWD_EN), DEPTH=2: slice 0 holds rd=4 with we=1 and slice 1 holds rd=6 with valid=0. Expect fwd_rd_o={6,4}, fwd_valid_o=2'b01, fwd_we_o=2'b01.
